// File: rtl/axi_wr_arbiter_pkg.sv
// Shared types and helpers for the AXI write arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  function automatic logic [2:0] clog2_bytes(input int unsigned dsize);
    logic [2:0] r;
    r = '0;
    for (int unsigned b = 0; b < 8; b++) begin
      if ((32'd1 << b) == dsize / 8) r = 3'(b);
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr_select.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_select #(
  parameter int unsigned N = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [N-1:0]  rot;
  logic [PW-1:0] off;
  logic [PW:0]   sum;

  always_comb begin
    rot     = N'({req, req} >> ptr);
    off     = '0;
    gnt_any = 1'b0;
    // Descending scan so the lowest rotated offset is the one that sticks.
    for (int unsigned i = N; i > 0; i--) begin
      if (rot[i-1]) begin
        off     = PW'(i - 1);
        gnt_any = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    gnt_idx = sum[PW-1:0];
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// Round-robin arbiter sharing one AXI write master among NUM_REQ requesters.
// Optional burst beat checking with `define AXI_WR_ARB_BEATCHK_EN (adds err_beat).
module axi_wr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ASIZE   = 32,
  parameter int unsigned DSIZE   = 64,
  parameter int unsigned LSIZE   = 8,
  parameter int unsigned IDSIZE  = 4
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic [NUM_REQ-1:0]            s_awvalid,
  input  logic [NUM_REQ*ASIZE-1:0]      s_awaddr,
  input  logic [NUM_REQ*LSIZE-1:0]      s_awlen,
  input  logic [NUM_REQ*2-1:0]          s_awburst,
  output logic [NUM_REQ-1:0]            s_awready,
  input  logic [NUM_REQ-1:0]            s_wvalid,
  input  logic [NUM_REQ*DSIZE-1:0]      s_wdata,
  input  logic [NUM_REQ*(DSIZE/8)-1:0]  s_wstrb,
  input  logic [NUM_REQ-1:0]            s_wlast,
  output logic [NUM_REQ-1:0]            s_wready,
  output logic [NUM_REQ-1:0]            s_bvalid,
  output logic [1:0]                    s_bresp,
  input  logic [NUM_REQ-1:0]            s_bready,
  output logic                          m_awvalid,
  output logic [ASIZE-1:0]              m_awaddr,
  output logic [LSIZE-1:0]              m_awlen,
  output logic [1:0]                    m_awburst,
  output logic [IDSIZE-1:0]             m_awid,
  output logic [2:0]                    m_awsize,
  input  logic                          m_awready,
  output logic                          m_wvalid,
  output logic [DSIZE-1:0]              m_wdata,
  output logic [DSIZE/8-1:0]            m_wstrb,
  output logic                          m_wlast,
  input  logic                          m_wready,
  input  logic                          m_bvalid,
  input  logic [1:0]                    m_bresp,
  output logic                          m_bready,
`ifdef AXI_WR_ARB_BEATCHK_EN
  output logic                          err_beat,
`endif
  output logic                          busy
);

  localparam int unsigned SSIZE  = DSIZE / 8;
  localparam int unsigned PW     = $clog2(NUM_REQ);
  localparam logic [2:0]  AWSIZE = clog2_bytes(DSIZE);

  arb_state_t        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [ASIZE-1:0]  awaddr_q, awaddr_d;
  logic [LSIZE-1:0]  awlen_q, awlen_d;
  logic [1:0]        awburst_q, awburst_d;
  logic [PW-1:0]     sel_idx;
  logic              sel_any;
  logic              w_beat;
`ifdef AXI_WR_ARB_BEATCHK_EN
  logic [LSIZE:0]    cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              at_len;
`endif

  logic [ASIZE-1:0]  awaddr_a  [NUM_REQ];
  logic [LSIZE-1:0]  awlen_a   [NUM_REQ];
  logic [1:0]        awburst_a [NUM_REQ];
  logic [DSIZE-1:0]  wdata_a   [NUM_REQ];
  logic [SSIZE-1:0]  wstrb_a   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign awaddr_a[gi]  = s_awaddr[gi*ASIZE +: ASIZE];
    assign awlen_a[gi]   = s_awlen[gi*LSIZE +: LSIZE];
    assign awburst_a[gi] = s_awburst[gi*2 +: 2];
    assign wdata_a[gi]   = s_wdata[gi*DSIZE +: DSIZE];
    assign wstrb_a[gi]   = s_wstrb[gi*SSIZE +: SSIZE];
  end

  rr_select #(.N(NUM_REQ)) u_rr_select (
    .req     (s_awvalid),
    .ptr     (rr_ptr_q),
    .gnt_idx (sel_idx),
    .gnt_any (sel_any)
  );

  assign busy = (state_q != IDLE);
`ifdef AXI_WR_ARB_BEATCHK_EN
  assign err_beat = err_q;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awburst_d = awburst_q;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    m_awvalid = 1'b0;
    m_awaddr  = '0;
    m_awlen   = '0;
    m_awburst = '0;
    m_awid    = '0;
    m_awsize  = '0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    w_beat    = 1'b0;
`ifdef AXI_WR_ARB_BEATCHK_EN
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    at_len = (cnt_q == {1'b0, awlen_q});
`endif
    case (state_q)
      IDLE: begin
        if (sel_any) begin
          grant_d   = sel_idx;
          awaddr_d  = awaddr_a[sel_idx];
          awlen_d   = awlen_a[sel_idx];
          awburst_d = awburst_a[sel_idx];
          state_d   = ADDR;
        end
      end
      ADDR: begin
        m_awvalid = 1'b1;
        m_awaddr  = awaddr_q;
        m_awlen   = awlen_q;
        m_awburst = awburst_q;
        m_awid    = IDSIZE'(grant_q);
        m_awsize  = AWSIZE;
        if (m_awready) begin
          s_awready[grant_q] = 1'b1;
          state_d            = DATA;
`ifdef AXI_WR_ARB_BEATCHK_EN
          cnt_d = '0;
`endif
        end
      end
      DATA: begin
        m_wvalid          = s_wvalid[grant_q];
        s_wready[grant_q] = m_wready;
        m_wdata           = wdata_a[grant_q];
        m_wstrb           = wstrb_a[grant_q];
        w_beat            = s_wvalid[grant_q] & m_wready;
`ifdef AXI_WR_ARB_BEATCHK_EN
        // Beat awlen+1 always closes the burst, flagged if wlast disagrees.
        m_wlast = s_wlast[grant_q] | at_len;
        if (w_beat) begin
          cnt_d = cnt_q + 1'b1;
          err_d = s_wlast[grant_q] ^ at_len;
        end
`else
        m_wlast = s_wlast[grant_q];
`endif
        if (w_beat && m_wlast) state_d = RESP;
      end
      RESP: begin
        s_bvalid[grant_q] = m_bvalid;
        m_bready          = s_bready[grant_q];
        s_bresp           = m_bresp;
        if (m_bvalid && s_bready[grant_q]) begin
          rr_ptr_d = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awburst_q <= '0;
`ifdef AXI_WR_ARB_BEATCHK_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awburst_q <= awburst_d;
`ifdef AXI_WR_ARB_BEATCHK_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed bench for axi_wr_arbiter with a transaction-level reference model.
module tb_axi_wr_arbiter;
  import axi_arb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int LW = 8;
  localparam int IW = 4;
  localparam int SW = DW / 8;

  typedef logic [1:0] rid_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [NR-1:0]    s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [NR*AW-1:0] s_awaddr;
  logic [NR*LW-1:0] s_awlen;
  logic [NR*2-1:0]  s_awburst;
  logic [NR*DW-1:0] s_wdata;
  logic [NR*SW-1:0] s_wstrb;
  logic [1:0]       s_bresp, m_bresp, m_awburst;
  logic             m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready, busy;
  logic [AW-1:0]    m_awaddr;
  logic [LW-1:0]    m_awlen;
  logic [IW-1:0]    m_awid;
  logic [2:0]       m_awsize;
  logic [DW-1:0]    m_wdata;
  logic [SW-1:0]    m_wstrb;
`ifdef AXI_WR_ARB_BEATCHK_EN
  logic             err_beat;
`endif

  axi_wr_arbiter #(.NUM_REQ(NR), .ASIZE(AW), .DSIZE(DW), .LSIZE(LW), .IDSIZE(IW)) dut (
    .axi_aclk(clk), .axi_resetn(rst_n),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awburst(s_awburst),
    .s_awready(s_awready), .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp),
    .s_bready(s_bready), .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
    .m_awburst(m_awburst), .m_awid(m_awid), .m_awsize(m_awsize), .m_awready(m_awready),
    .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wready(m_wready), .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
`ifdef AXI_WR_ARB_BEATCHK_EN
    .err_beat(err_beat),
`endif
    .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Requester-side drive, one element per requester.
  logic          aw_v [NR];
  logic [AW-1:0] aw_a [NR];
  logic [LW-1:0] aw_l [NR];
  logic [1:0]    aw_b [NR];
  logic          w_v  [NR];
  logic [DW-1:0] w_d  [NR];
  logic [SW-1:0] w_s  [NR];
  logic          w_l  [NR];
  logic          b_r  [NR];
  logic [1:0]    b_seen [NR];

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      s_awvalid[i]         = aw_v[i];
      s_awaddr[i*AW +: AW] = aw_a[i];
      s_awlen[i*LW +: LW]  = aw_l[i];
      s_awburst[i*2 +: 2]  = aw_b[i];
      s_wvalid[i]          = w_v[i];
      s_wdata[i*DW +: DW]  = w_d[i];
      s_wstrb[i*SW +: SW]  = w_s[i];
      s_wlast[i]           = w_l[i];
      s_bready[i]          = b_r[i];
    end
  end

  // Slave-side ready/valid patterns.
  bit tog_en = 1'b0;
  bit stall_en = 1'b0;
  int cyc = 0;
  initial begin
    m_awready = 1'b1;
    m_wready  = 1'b1;
    m_bvalid  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      m_wready  = tog_en ? ~m_wready : 1'b1;
      m_awready = stall_en ? (cyc % 3 != 0) : 1'b1;
      m_bvalid  = stall_en ? (cyc % 2 == 0) : 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observation logs filled by the compare process.
  int            aw_ids[$];
  logic [AW-1:0] aw_addrs[$];
  logic [LW-1:0] aw_lens[$];
  logic [DW-1:0] w_datas[$];
  logic          w_lasts[$];
  int            idle_cnt = 0;
  int            other_wr = 0;
  bit            watch_wr = 1'b0;
  int            err_cnt = 0;

  task automatic clear_logs();
    aw_ids.delete(); aw_addrs.delete(); aw_lens.delete();
    w_datas.delete(); w_lasts.delete();
  endtask

  // Reference model: phase 0 idle, 1 address, 2 data, 3 response.
  int            mph = 0, mg = 0, mptr = 0, mcnt = 0;
  logic [AW-1:0] maddr;
  logic [LW-1:0] mlen;
  logic [1:0]    mbur;
  bit            merr = 1'b0;
  rid_t          gr;
  logic [NR-1:0] e_awr, e_wr, e_bv;
  logic          e_last;
  bit            found;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_s_awready", s_awready, 0);
      chk("rst_s_wready", s_wready, 0);
      chk("rst_s_bvalid", s_bvalid, 0);
      chk("rst_m_awvalid", m_awvalid, 0);
      chk("rst_m_awaddr", m_awaddr, 0);
      chk("rst_m_awid", m_awid, 0);
      chk("rst_m_wvalid", m_wvalid, 0);
      chk("rst_m_wdata", m_wdata, 0);
      chk("rst_m_bready", m_bready, 0);
      chk("rst_busy", busy, 0);
      mph = 0; mptr = 0; mg = 0; mcnt = 0; merr = 1'b0;
    end else begin
      gr     = rid_t'(mg);
      e_awr  = '0;
      e_wr   = '0;
      e_bv   = '0;
      e_last = s_wlast[gr];
`ifdef AXI_WR_ARB_BEATCHK_EN
      e_last = e_last | (mcnt == int'(mlen));
`endif
      if (mph == 1 && m_awready) e_awr[gr] = 1'b1;
      if (mph == 2) e_wr[gr] = m_wready;
      if (mph == 3) e_bv[gr] = m_bvalid;
      chk("busy", busy, mph != 0);
      chk("m_awvalid", m_awvalid, mph == 1);
      chk("s_awready", s_awready, e_awr);
      chk("m_wvalid", m_wvalid, mph == 2 && s_wvalid[gr]);
      chk("s_wready", s_wready, e_wr);
      chk("s_bvalid", s_bvalid, e_bv);
      chk("m_bready", m_bready, mph == 3 && s_bready[gr]);
      if (mph == 1) begin
        chk("m_awaddr", m_awaddr, maddr);
        chk("m_awlen", m_awlen, mlen);
        chk("m_awburst", m_awburst, mbur);
        chk("m_awid", m_awid, mg);
        chk("m_awsize", m_awsize, 3);
      end
      if (mph == 2 && s_wvalid[gr]) begin
        chk("m_wdata", m_wdata, s_wdata[mg*DW +: DW]);
        chk("m_wstrb", m_wstrb, s_wstrb[mg*SW +: SW]);
        chk("m_wlast", m_wlast, e_last);
      end
      if (e_bv != 0) chk("s_bresp", s_bresp, m_bresp);
`ifdef AXI_WR_ARB_BEATCHK_EN
      chk("err_beat", err_beat, merr);
      if (err_beat) err_cnt++;
`endif
      if (m_awvalid && m_awready) begin
        aw_ids.push_back(int'(m_awid)); aw_addrs.push_back(m_awaddr); aw_lens.push_back(m_awlen);
      end
      if (m_wvalid && m_wready) begin
        w_datas.push_back(m_wdata); w_lasts.push_back(m_wlast);
      end
      if (!busy) idle_cnt++;
      if (watch_wr && ((s_wready & 4'b1011) != 0)) other_wr++;

      merr = 1'b0;
      case (mph)
        0: begin
          found = 1'b0;
          for (int k = 0; k < NR; k++) begin
            if (!found && s_awvalid[(mptr + k) % NR]) begin
              found = 1'b1;
              mg    = (mptr + k) % NR;
            end
          end
          if (found) begin
            maddr = s_awaddr[mg*AW +: AW];
            mlen  = s_awlen[mg*LW +: LW];
            mbur  = s_awburst[mg*2 +: 2];
            mph   = 1;
          end
        end
        1: if (m_awready) begin mph = 2; mcnt = 0; end
        2: if (s_wvalid[gr] && m_wready) begin
`ifdef AXI_WR_ARB_BEATCHK_EN
             merr = (s_wlast[gr] != (mcnt == int'(mlen)));
`endif
             if (e_last) mph = 3;
             mcnt++;
           end
        3: if (m_bvalid && s_bready[gr]) begin mptr = (mg + 1) % NR; mph = 0; end
        default: mph = 0;
      endcase
    end
  end

  // sel: 0 awready, 1 wready, 2 bvalid; bounded wait sampled on negedge.
  task automatic wait_neg(input int sel, input rid_t r);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < 300 && !hit; t++) begin
      @(negedge clk);
      hit = (sel == 0) ? s_awready[r] : (sel == 1) ? s_wready[r] : s_bvalid[r];
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout sel=%0d req=%0d: got no handshake expected handshake", sel, r);
    end
  endtask

  task automatic do_write(input rid_t r, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                          input logic [DW-1:0] dbase, input int last_at, input bit gap);
    aw_v[r] = 1'b1; aw_a[r] = addr; aw_l[r] = len; aw_b[r] = AXI_BURST_INCR;
    wait_neg(0, r);
    @(posedge clk); #1;
    aw_v[r] = 1'b0; aw_a[r] = '0; aw_l[r] = '0; aw_b[r] = '0;
    for (int b = 0; b <= last_at; b++) begin
      if (gap && (b % 2 == 1)) begin
        w_v[r] = 1'b0;
        @(posedge clk); #1;
      end
      w_v[r] = 1'b1; w_d[r] = dbase + DW'(b); w_s[r] = 8'hF0 | 8'(b); w_l[r] = (b == last_at);
      wait_neg(1, r);
      @(posedge clk); #1;
    end
    w_v[r] = 1'b0; w_l[r] = 1'b0; w_d[r] = '0; w_s[r] = '0;
    b_r[r] = 1'b1;
    wait_neg(2, r);
    b_seen[r] = s_bresp;
    @(posedge clk); #1;
    b_r[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [DW-1:0] t1_data [4] = '{64'hA, 64'hB, 64'hC, 64'hD};
  int            t2_ord  [3] = '{0, 2, 3};
  int            t3_ord  [3] = '{0, 1, 0};
  int            nlast;

  initial begin
    for (int i = 0; i < NR; i++) begin
      aw_v[i] = 0; aw_a[i] = '0; aw_l[i] = '0; aw_b[i] = '0; w_v[i] = 0;
      w_d[i] = '0; w_s[i] = '0; w_l[i] = 0; b_r[i] = 0; b_seen[i] = 2'b11;
    end
    m_bresp = AXI_RESP_OKAY;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_m_awvalid", m_awvalid, 0);
    chk("reset_s_awready", s_awready, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single requester burst.
    clear_logs();
    do_write(2'd1, 32'h1000, 8'd3, 64'hA, 3, 1'b0);
    chk("t1_aw_count", aw_ids.size(), 1);
    if (aw_ids.size() == 1) begin
      chk("t1_awid", aw_ids[0], 1);
      chk("t1_awaddr", aw_addrs[0], 32'h1000);
      chk("t1_awlen", aw_lens[0], 3);
    end
    chk("t1_w_count", w_datas.size(), 4);
    if (w_datas.size() == 4) begin
      for (int b = 0; b < 4; b++) begin
        chk("t1_wdata", w_datas[b], t1_data[b]);
        chk("t1_wlast", w_lasts[b], b == 3);
      end
    end
    chk("t1_bresp", b_seen[1], 2'b00);

    // Three simultaneous requests straight from reset.
    do_reset();
    clear_logs();
    idle_cnt = 0;
    fork
      do_write(2'd0, 32'h2000, 8'd1, 64'h100, 1, 1'b0);
      do_write(2'd2, 32'h2200, 8'd1, 64'h200, 1, 1'b0);
      do_write(2'd3, 32'h2300, 8'd1, 64'h300, 1, 1'b0);
    join
    chk("t2_aw_count", aw_ids.size(), 3);
    if (aw_ids.size() == 3)
      for (int k = 0; k < 3; k++) chk("t2_order", aw_ids[k], t2_ord[k]);
    chk("t2_idle_cycles", idle_cnt, 3);

    // Persistent requester 0 against a single request from 1.
    clear_logs();
    m_bresp  = 2'b10;
    stall_en = 1'b1;
    fork
      begin
        do_write(2'd0, 32'h3000, 8'd0, 64'h10, 0, 1'b0);
        do_write(2'd0, 32'h3100, 8'd0, 64'h11, 0, 1'b0);
      end
      do_write(2'd1, 32'h3200, 8'd0, 64'h12, 0, 1'b0);
    join
    stall_en = 1'b0;
    chk("t3_aw_count", aw_ids.size(), 3);
    if (aw_ids.size() == 3)
      for (int k = 0; k < 3; k++) chk("t3_order", aw_ids[k], t3_ord[k]);
    chk("t3_bresp_pass", b_seen[1], 2'b10);

    // 8-beat burst with toggling wready and gapped wvalid.
    clear_logs();
    m_bresp  = AXI_RESP_OKAY;
    other_wr = 0;
    tog_en   = 1'b1;
    watch_wr = 1'b1;
    do_write(2'd2, 32'h5000, 8'd7, 64'h20, 7, 1'b1);
    tog_en   = 1'b0;
    watch_wr = 1'b0;
    chk("t4_w_count", w_datas.size(), 8);
    nlast = 0;
    foreach (w_lasts[k]) if (w_lasts[k]) nlast++;
    chk("t4_wlast_count", nlast, 1);
    if (w_datas.size() == 8) begin
      chk("t4_wlast_final", w_lasts[7], 1);
      for (int b = 0; b < 8; b++) chk("t4_wdata", w_datas[b], 64'h20 + 64'(b));
    end
    chk("t4_other_wready", other_wr, 0);

    // Asynchronous reset during the second beat of a burst.
    aw_v[1] = 1'b1; aw_a[1] = 32'h6600; aw_l[1] = 8'd3; aw_b[1] = AXI_BURST_INCR;
    wait_neg(0, 2'd1);
    @(posedge clk); #1;
    aw_v[1] = 1'b0;
    w_v[1] = 1'b1; w_d[1] = 64'h30; w_s[1] = 8'hFF; w_l[1] = 1'b0;
    wait_neg(1, 2'd1);
    @(posedge clk); #1;
    w_d[1] = 64'h31;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_m_wvalid", m_wvalid, 0);
    chk("arst_s_wready", s_wready, 0);
    chk("arst_m_wdata", m_wdata, 0);
    chk("arst_busy", busy, 0);
    chk("arst_m_awvalid", m_awvalid, 0);
    w_v[1] = 1'b0; w_d[1] = '0; w_s[1] = '0;
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    do_write(2'd3, 32'h6000, 8'd1, 64'h40, 1, 1'b0);
    chk("t5_aw_count", aw_ids.size(), 1);
    if (aw_ids.size() == 1) begin
      chk("t5_awid", aw_ids[0], 3);
      chk("t5_awaddr", aw_addrs[0], 32'h6000);
    end
    chk("t5_w_count", w_datas.size(), 2);

    // Early wlast on beat 2 of a 4-beat burst.
    clear_logs();
    m_bresp = 2'b01;
    err_cnt = 0;
    do_write(2'd0, 32'h7000, 8'd3, 64'h50, 1, 1'b0);
    chk("t6_w_count", w_datas.size(), 2);
    chk("t6_bresp", b_seen[0], 2'b01);
    repeat (3) @(posedge clk);
`ifdef AXI_WR_ARB_BEATCHK_EN
    chk("t6_err_pulses", err_cnt, 1);
`endif

    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected completion by 200000");
    $fatal(1, "watchdog");
  end

endmodule
